// File: rtl/mem_pkg.sv
// Shared definitions for the dual-port memory: init FSM encoding,
// read-during-write mode constants and the address-width helper.
package mem_pkg;

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } init_state_e;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // A one-word memory still needs a one-bit address bus.
  function automatic int addr_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/mem_init_seq.sv
// Post-reset clear sequencer: walks every address once writing zero,
// then raises ready and stays in S_RUN until the next reset.
module mem_init_seq
  import mem_pkg::*;
#(
  parameter  int MEM_SIZE = 1024,
  localparam int ADDR_W   = addr_w(MEM_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic              ready,
  output init_state_e       state
);

  logic [ADDR_W-1:0] init_cnt;

  // The last-address compare is done at 32 bits so sizes that are not a
  // power of two stop at MEM_SIZE-1 instead of wrapping the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      init_cnt <= '0;
      ready    <= 1'b0;
    end else if (state == S_INIT) begin
      if (32'(init_cnt) == 32'(MEM_SIZE - 1)) begin
        state <= S_RUN;
        ready <= 1'b1;
      end else begin
        init_cnt <= init_cnt + ADDR_W'(1);
      end
    end else begin
      ready <= 1'b1;
    end
  end

  assign init_we   = (state == S_INIT);
  assign init_addr = init_cnt;

endmodule

// File: rtl/memory_dp.sv
// Simple dual-port RAM with one write and one read port on a single clock,
// post-reset clearing, 1- or 2-cycle read latency and selectable RDW mode.
module memory_dp
  import mem_pkg::*;
#(
  parameter  int DATA_LENGTH  = 8,
  parameter  int MEM_SIZE     = 1024,
  parameter  int READ_LATENCY = 1,
  parameter  int RDW_MODE     = 0,
  localparam int ADDR_W       = addr_w(MEM_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wen,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [DATA_LENGTH-1:0] din,
  input  logic                   ren,
  input  logic [ADDR_W-1:0]      raddr,
  output logic [DATA_LENGTH-1:0] dout,
  output logic                   rvalid,
  output logic                   ready
);

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("memory_dp: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  init_state_e       init_state;

  mem_init_seq #(
    .MEM_SIZE(MEM_SIZE)
  ) u_init_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_we  (init_we),
    .init_addr(init_addr),
    .ready    (ready),
    .state    (init_state)
  );

  logic [DATA_LENGTH-1:0] mem [MEM_SIZE];

  logic                   user_we;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_waddr;
  logic [DATA_LENGTH-1:0] mem_wdata;

  // The clear sequencer owns the write port until it hands over to S_RUN.
  assign user_we   = (init_state == S_RUN) && wen && (32'(waddr) < 32'(MEM_SIZE));
  assign mem_we    = init_we || user_we;
  assign mem_waddr = init_we ? init_addr : waddr;
  assign mem_wdata = init_we ? '0 : din;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read handshake: a request is taken on any rising edge where ren and
  // ready are both high; there is no backpressure. rvalid marks the cycle
  // whose dout answers the request taken READ_LATENCY edges earlier, and
  // dout holds its previous value whenever rvalid is low.
  logic                   rd_fire;
  logic                   raddr_ok;
  logic                   collide;
  logic [DATA_LENGTH-1:0] rd_word;

  assign rd_fire  = ren && ready;
  assign raddr_ok = (32'(raddr) < 32'(MEM_SIZE));
  assign collide  = user_we && (waddr == raddr);

  always_comb begin
    rd_word = '0;
    if (raddr_ok) begin
      if (RDW_MODE == RDW_NEW && collide) begin
        rd_word = din;
      end else begin
        rd_word = mem[raddr];
      end
    end
  end

  logic [DATA_LENGTH-1:0] rd1_data;
  logic                   rd1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_data  <= '0;
      rd1_valid <= 1'b0;
    end else begin
      rd1_valid <= rd_fire;
      if (rd_fire) begin
        rd1_data <= rd_word;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_LENGTH-1:0] rd2_data;
      logic                   rd2_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd2_data  <= '0;
          rd2_valid <= 1'b0;
        end else begin
          rd2_valid <= rd1_valid;
          if (rd1_valid) begin
            rd2_data <= rd1_data;
          end
        end
      end

      assign dout   = rd2_data;
      assign rvalid = rd2_valid;
    end else begin : g_lat1
      assign dout   = rd1_data;
      assign rvalid = rd1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_memory_dp.sv
// Directed bench for memory_dp: three instances share one stimulus stream
// (16 words/lat 1/old-data, 16 words/lat 2/new-data, 24 words/lat 2/old-data).
module tb_memory_dp;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       wen   = 1'b0;
  logic       ren   = 1'b0;
  logic [4:0] waddr = '0;
  logic [4:0] raddr = '0;
  logic [7:0] din   = '0;

  logic [7:0] dout_a, dout_b, dout_c;
  logic       rvalid_a, rvalid_b, rvalid_c;
  logic       ready_a, ready_b, ready_c;

  int errors = 0;
  int checks = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  memory_dp #(.DATA_LENGTH(8), .MEM_SIZE(16), .READ_LATENCY(1), .RDW_MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr[3:0]), .din(din),
    .ren(ren), .raddr(raddr[3:0]), .dout(dout_a), .rvalid(rvalid_a), .ready(ready_a)
  );

  memory_dp #(.DATA_LENGTH(8), .MEM_SIZE(16), .READ_LATENCY(2), .RDW_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr[3:0]), .din(din),
    .ren(ren), .raddr(raddr[3:0]), .dout(dout_b), .rvalid(rvalid_b), .ready(ready_b)
  );

  memory_dp #(.DATA_LENGTH(8), .MEM_SIZE(24), .READ_LATENCY(2), .RDW_MODE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .din(din),
    .ren(ren), .raddr(raddr), .dout(dout_c), .rvalid(rvalid_c), .ready(ready_c)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wen = 1'b0; ren = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 64 && !(ready_a && ready_b && ready_c); i++) tick();
    checks++;
    if (!(ready_a && ready_b && ready_c)) begin
      errors++;
      $display("FAIL wait_ready: ready a/b/c=%b%b%b required 111 within 64 cycles", ready_a, ready_b, ready_c);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wen = 1'b0; ren = 1'b0;
    tick(); tick();
    checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL reset ready_a: got %b expected 0", ready_a); end
    checks++; if (ready_b !== 1'b0) begin errors++; $display("FAIL reset ready_b: got %b expected 0", ready_b); end
    checks++; if (ready_c !== 1'b0) begin errors++; $display("FAIL reset ready_c: got %b expected 0", ready_c); end
    checks++; if (rvalid_a !== 1'b0) begin errors++; $display("FAIL reset rvalid_a: got %b expected 0", rvalid_a); end
    checks++; if (rvalid_b !== 1'b0) begin errors++; $display("FAIL reset rvalid_b: got %b expected 0", rvalid_b); end
    checks++; if (rvalid_c !== 1'b0) begin errors++; $display("FAIL reset rvalid_c: got %b expected 0", rvalid_c); end
    checks++; if (dout_a !== 8'h00) begin errors++; $display("FAIL reset dout_a: got %h expected 00", dout_a); end
    checks++; if (dout_b !== 8'h00) begin errors++; $display("FAIL reset dout_b: got %h expected 00", dout_b); end
    checks++; if (dout_c !== 8'h00) begin errors++; $display("FAIL reset dout_c: got %h expected 00", dout_c); end
    rst_n = 1'b1;
    // ready must appear right after the MEM_SIZE-th edge following release
    for (int i = 1; i <= 26; i++) begin
      tick();
      checks++; if (ready_a !== (i >= 16)) begin errors++; $display("FAIL init_time ready_a cycle %0d: got %b expected %b", i, ready_a, (i >= 16)); end
      checks++; if (ready_b !== (i >= 16)) begin errors++; $display("FAIL init_time ready_b cycle %0d: got %b expected %b", i, ready_b, (i >= 16)); end
      checks++; if (ready_c !== (i >= 24)) begin errors++; $display("FAIL init_time ready_c cycle %0d: got %b expected %b", i, ready_c, (i >= 24)); end
    end
  endtask

  task automatic test_init_zero();
    for (int k = 0; k < 16; k++) begin
      ren = 1'b1; raddr = 5'(k);
      tick();
      checks++; if (rvalid_a !== 1'b1 || dout_a !== 8'h00) begin errors++; $display("FAIL init_zero_a addr %0d: got v=%b d=%h expected v=1 d=00", k, rvalid_a, dout_a); end
      checks++; if (rvalid_b !== (k > 0) || dout_b !== 8'h00) begin errors++; $display("FAIL init_zero_b addr %0d: got v=%b d=%h expected v=%b d=00", k, rvalid_b, dout_b, (k > 0)); end
      checks++; if (rvalid_c !== (k > 0) || dout_c !== 8'h00) begin errors++; $display("FAIL init_zero_c addr %0d: got v=%b d=%h expected v=%b d=00", k, rvalid_c, dout_c, (k > 0)); end
    end
    ren = 1'b0;
    tick();
    checks++; if (rvalid_a !== 1'b0) begin errors++; $display("FAIL init_zero_tail rvalid_a: got %b expected 0", rvalid_a); end
    checks++; if (rvalid_b !== 1'b1 || dout_b !== 8'h00) begin errors++; $display("FAIL init_zero_tail b: got v=%b d=%h expected v=1 d=00", rvalid_b, dout_b); end
    tick();
    checks++; if (rvalid_b !== 1'b0) begin errors++; $display("FAIL init_zero_end rvalid_b: got %b expected 0", rvalid_b); end
  endtask

  task automatic test_write_read();
    wen = 1'b1; waddr = 5'd10; din = 8'hA5;
    tick();
    wen = 1'b0; ren = 1'b1; raddr = 5'd10;
    tick();
    ren = 1'b0;
    checks++; if (rvalid_a !== 1'b1 || dout_a !== 8'hA5) begin errors++; $display("FAIL wr_rd_a: got v=%b d=%h expected v=1 d=a5", rvalid_a, dout_a); end
    checks++; if (rvalid_b !== 1'b0) begin errors++; $display("FAIL wr_rd_b_early rvalid: got %b expected 0", rvalid_b); end
    tick();
    checks++; if (rvalid_a !== 1'b0 || dout_a !== 8'hA5) begin errors++; $display("FAIL wr_rd_a_hold: got v=%b d=%h expected v=0 d=a5", rvalid_a, dout_a); end
    checks++; if (rvalid_b !== 1'b1 || dout_b !== 8'hA5) begin errors++; $display("FAIL wr_rd_b: got v=%b d=%h expected v=1 d=a5", rvalid_b, dout_b); end
    checks++; if (rvalid_c !== 1'b1 || dout_c !== 8'hA5) begin errors++; $display("FAIL wr_rd_c: got v=%b d=%h expected v=1 d=a5", rvalid_c, dout_c); end
    ren = 1'b1; raddr = 5'd20;
    tick();
    ren = 1'b0;
    checks++; if (rvalid_a !== 1'b1 || dout_a !== 8'h00) begin errors++; $display("FAIL rd_unwritten_a: got v=%b d=%h expected v=1 d=00", rvalid_a, dout_a); end
    tick();
    checks++; if (rvalid_c !== 1'b1 || dout_c !== 8'h00) begin errors++; $display("FAIL rd_addr20_c: got v=%b d=%h expected v=1 d=00", rvalid_c, dout_c); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    for (int k = 1; k <= 3; k++) begin
      wen = 1'b1; waddr = 5'(k); din = 8'(k * 17);
      tick();
    end
    wen = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      ren = (cyc < 3); raddr = 5'(cyc + 1);
      tick();
      exp = (cyc < 3) ? 8'((cyc + 1) * 17) : 8'h33;
      checks++; if (rvalid_a !== (cyc < 3) || dout_a !== exp) begin errors++; $display("FAIL b2b_a cycle %0d: got v=%b d=%h expected v=%b d=%h", cyc, rvalid_a, dout_a, (cyc < 3), exp); end
      exp = (cyc >= 1 && cyc <= 3) ? 8'(cyc * 17) : 8'h33;
      checks++; if (rvalid_b !== (cyc >= 1 && cyc <= 3) || (cyc > 0 && dout_b !== exp)) begin errors++; $display("FAIL b2b_b cycle %0d: got v=%b d=%h expected v=%b d=%h", cyc, rvalid_b, dout_b, (cyc >= 1 && cyc <= 3), exp); end
      checks++; if (rvalid_c !== (cyc >= 1 && cyc <= 3) || (cyc > 0 && dout_c !== exp)) begin errors++; $display("FAIL b2b_c cycle %0d: got v=%b d=%h expected v=%b d=%h", cyc, rvalid_c, dout_c, (cyc >= 1 && cyc <= 3), exp); end
    end
    ren = 1'b0;
  endtask

  task automatic test_collision();
    wen = 1'b1; waddr = 5'd5; din = 8'h3C;
    tick();
    din = 8'hC3; ren = 1'b1; raddr = 5'd5;
    tick();
    wen = 1'b0; ren = 1'b0;
    checks++; if (rvalid_a !== 1'b1 || dout_a !== 8'h3C) begin errors++; $display("FAIL rdw_old_a: got v=%b d=%h expected v=1 d=3c", rvalid_a, dout_a); end
    tick();
    checks++; if (rvalid_b !== 1'b1 || dout_b !== 8'hC3) begin errors++; $display("FAIL rdw_new_b: got v=%b d=%h expected v=1 d=c3", rvalid_b, dout_b); end
    checks++; if (rvalid_c !== 1'b1 || dout_c !== 8'h3C) begin errors++; $display("FAIL rdw_old_c: got v=%b d=%h expected v=1 d=3c", rvalid_c, dout_c); end
    ren = 1'b1; raddr = 5'd5;
    tick();
    ren = 1'b0;
    checks++; if (dout_a !== 8'hC3) begin errors++; $display("FAIL rdw_after_a: got %h expected c3", dout_a); end
    tick();
    checks++; if (dout_b !== 8'hC3) begin errors++; $display("FAIL rdw_after_b: got %h expected c3", dout_b); end
    checks++; if (dout_c !== 8'hC3) begin errors++; $display("FAIL rdw_after_c: got %h expected c3", dout_c); end
    // independent ports: write 6 while reading 10
    wen = 1'b1; waddr = 5'd6; din = 8'h5A; ren = 1'b1; raddr = 5'd10;
    tick();
    wen = 1'b0; raddr = 5'd6;
    checks++; if (dout_a !== 8'hA5) begin errors++; $display("FAIL par_rd_a: got %h expected a5", dout_a); end
    tick();
    ren = 1'b0;
    checks++; if (dout_a !== 8'h5A) begin errors++; $display("FAIL par_wr_a: got %h expected 5a", dout_a); end
    checks++; if (dout_b !== 8'hA5) begin errors++; $display("FAIL par_rd_b: got %h expected a5", dout_b); end
    tick();
    checks++; if (dout_b !== 8'h5A || dout_c !== 8'h5A) begin errors++; $display("FAIL par_wr_bc: got b=%h c=%h expected 5a 5a", dout_b, dout_c); end
  endtask

  task automatic test_out_of_range();
    wen = 1'b1; waddr = 5'd20; din = 8'h99;
    tick();
    waddr = 5'd26; din = 8'h77;
    tick();
    wen = 1'b0; ren = 1'b1; raddr = 5'd20;
    tick();
    raddr = 5'd26;
    tick();
    ren = 1'b0;
    checks++; if (rvalid_c !== 1'b1 || dout_c !== 8'h99) begin errors++; $display("FAIL oor_in_range_c: got v=%b d=%h expected v=1 d=99", rvalid_c, dout_c); end
    tick();
    checks++; if (rvalid_c !== 1'b1 || dout_c !== 8'h00) begin errors++; $display("FAIL oor_read_c: got v=%b d=%h expected v=1 d=00", rvalid_c, dout_c); end
    tick();
    checks++; if (rvalid_c !== 1'b0 || dout_c !== 8'h00) begin errors++; $display("FAIL oor_hold_c: got v=%b d=%h expected v=0 d=00", rvalid_c, dout_c); end
  endtask

  task automatic test_init_ignore();
    do_reset();
    tick(); tick();
    wen = 1'b1; waddr = 5'd2; din = 8'hFF; ren = 1'b1; raddr = 5'd2;
    tick();
    wen = 1'b0; ren = 1'b0;
    for (int j = 0; j < 3; j++) begin
      checks++; if ({rvalid_a, rvalid_b, rvalid_c} !== 3'b000) begin errors++; $display("FAIL init_ignore rvalid step %0d: got %b%b%b expected 000", j, rvalid_a, rvalid_b, rvalid_c); end
      tick();
    end
    wait_ready();
    ren = 1'b1; raddr = 5'd2;
    tick();
    ren = 1'b0;
    checks++; if (rvalid_a !== 1'b1 || dout_a !== 8'h00) begin errors++; $display("FAIL init_ignore_a addr2: got v=%b d=%h expected v=1 d=00", rvalid_a, dout_a); end
    tick();
    checks++; if (dout_b !== 8'h00 || dout_c !== 8'h00 || rvalid_b !== 1'b1) begin errors++; $display("FAIL init_ignore_bc addr2: got b=%h c=%h vb=%b expected 00 00 1", dout_b, dout_c, rvalid_b); end
  endtask

  task automatic test_reset_mid_read();
    wen = 1'b1; waddr = 5'd7; din = 8'h6E;
    tick();
    waddr = 5'd12; din = 8'hE6;
    tick();
    wen = 1'b0; ren = 1'b1; raddr = 5'd7;
    tick();
    raddr = 5'd12;
    tick();
    ren = 1'b0;
    checks++; if (dout_a !== 8'hE6 || dout_b !== 8'h6E) begin errors++; $display("FAIL mid_setup: got a=%h b=%h expected e6 6e", dout_a, dout_b); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ready_a, rvalid_a, dout_a} !== 10'h000) begin errors++; $display("FAIL mid_reset_a: got r=%b v=%b d=%h expected 0 0 00", ready_a, rvalid_a, dout_a); end
    checks++; if ({ready_b, rvalid_b, dout_b} !== 10'h000) begin errors++; $display("FAIL mid_reset_b: got r=%b v=%b d=%h expected 0 0 00", ready_b, rvalid_b, dout_b); end
    checks++; if ({ready_c, rvalid_c, dout_c} !== 10'h000) begin errors++; $display("FAIL mid_reset_c: got r=%b v=%b d=%h expected 0 0 00", ready_c, rvalid_c, dout_c); end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 26; i++) begin
      tick();
      checks++; if ({rvalid_a, rvalid_b, rvalid_c} !== 3'b000) begin errors++; $display("FAIL mid_rerun rvalid cycle %0d: got %b%b%b expected 000", i, rvalid_a, rvalid_b, rvalid_c); end
    end
    wait_ready();
    ren = 1'b1; raddr = 5'd7;
    tick();
    raddr = 5'd12;
    checks++; if (dout_a !== 8'h00) begin errors++; $display("FAIL mid_clear_a7: got %h expected 00", dout_a); end
    tick();
    ren = 1'b0;
    checks++; if (dout_a !== 8'h00 || dout_b !== 8'h00 || dout_c !== 8'h00) begin errors++; $display("FAIL mid_clear_12_7: got a=%h b=%h c=%h expected 00", dout_a, dout_b, dout_c); end
    tick();
    checks++; if (dout_b !== 8'h00 || dout_c !== 8'h00 || rvalid_c !== 1'b1) begin errors++; $display("FAIL mid_clear_bc12: got b=%h c=%h vc=%b expected 00 00 1", dout_b, dout_c, rvalid_c); end
  endtask

  initial begin
    test_reset();
    test_init_zero();
    test_write_read();
    test_back_to_back();
    test_collision();
    test_out_of_range();
    test_init_ignore();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
